// File: rtl/bip_pkg.sv
// BIP control unit shared definitions: opcodes, mux encodings, FSM states, control word.
// Ports: none (package); imported by bip_op_decoder and bip_control_unit.
// Opcode width is fixed here at 5 bits; the top checks its OPCODE_LEN against it.
package bip_pkg;

  localparam int OPCODE_W = 5;
  typedef logic [OPCODE_W-1:0] opcode_t;

  localparam opcode_t OP_HLT  = 5'b00000;
  localparam opcode_t OP_STO  = 5'b00001;
  localparam opcode_t OP_LD   = 5'b00010;
  localparam opcode_t OP_LDI  = 5'b00011;
  localparam opcode_t OP_ADD  = 5'b00100;
  localparam opcode_t OP_ADDI = 5'b00101;
  localparam opcode_t OP_SUB  = 5'b00110;
  localparam opcode_t OP_SUBI = 5'b00111;

  localparam logic [1:0] SEL_A_RAM = 2'd0;
  localparam logic [1:0] SEL_A_IMM = 2'd1;
  localparam logic [1:0] SEL_A_ALU = 2'd2;
  localparam logic       SEL_B_RAM = 1'b0;
  localparam logic       SEL_B_IMM = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  typedef struct packed {
    logic       pc_ena;
    logic [1:0] sel_a;
    logic       sel_b;
    logic       op_sub;
    logic       wr_acc;
    logic       wr_ram;
    logic       rd_ram;
  } ctrl_t;

endpackage

// File: rtl/bip_control_unit_if.sv
// Fetch/control bus between the BIP control unit and the PC/program memory/datapath.
// master: control unit (consumes instr_in, drives controls and operand).
// slave: PC, program memory and datapath side (drives instr_in, consumes controls).
interface bip_control_unit_if #(
  parameter int INSTR_LEN  = 16,
  parameter int OPCODE_LEN = 5
);
  logic [INSTR_LEN-1:0]            instr_in;
  logic                            pc_ena;
  logic [1:0]                      sel_a;
  logic                            sel_b;
  logic                            op_sub;
  logic                            wr_acc;
  logic                            wr_ram;
  logic                            rd_ram;
  logic [INSTR_LEN-OPCODE_LEN-1:0] operand;

  modport master (
    input  instr_in,
    output pc_ena, sel_a, sel_b, op_sub, wr_acc, wr_ram, rd_ram, operand
  );

  modport slave (
    output instr_in,
    input  pc_ena, sel_a, sel_b, op_sub, wr_acc, wr_ram, rd_ram, operand
  );
endinterface

// File: rtl/bip_op_decoder.sv
// Purely combinational opcode -> control word table with undefined-opcode flag.
// Ports: opcode in; ctrl (pc_ena, muxes, ALU op, enables) and illegal out.
// Undefined opcodes decode as a NOP that still advances the PC.
module bip_op_decoder
  import bip_pkg::*;
(
  input  opcode_t opcode,
  output ctrl_t   ctrl,
  output logic    illegal
);

  always_comb begin
    ctrl        = '0;
    ctrl.pc_ena = 1'b1;
    illegal     = 1'b0;
    case (opcode)
      OP_HLT: ctrl.pc_ena = 1'b0;
      OP_STO: ctrl.wr_ram = 1'b1;
      OP_LD: begin
        ctrl.rd_ram = 1'b1;
        ctrl.sel_a  = SEL_A_RAM;
        ctrl.wr_acc = 1'b1;
      end
      OP_LDI: begin
        ctrl.sel_a  = SEL_A_IMM;
        ctrl.wr_acc = 1'b1;
      end
      OP_ADD, OP_SUB: begin
        ctrl.rd_ram = 1'b1;
        ctrl.sel_b  = SEL_B_RAM;
        ctrl.sel_a  = SEL_A_ALU;
        ctrl.op_sub = (opcode == OP_SUB);
        ctrl.wr_acc = 1'b1;
      end
      OP_ADDI, OP_SUBI: begin
        ctrl.sel_b  = SEL_B_IMM;
        ctrl.sel_a  = SEL_A_ALU;
        ctrl.op_sub = (opcode == OP_SUBI);
        ctrl.wr_acc = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/bip_control_unit.sv
// BIP control unit: run/halt FSM, RUN-qualified instruction decode, sticky illegal-opcode flag.
// Ports: clk, reset (sync, active-high), start, bus (master: instr_in -> controls/operand),
//        halted, illegal_op, and cycle_count when BIP_CYCLE_COUNT_EN is defined (saturating RUN counter).
module bip_control_unit
  import bip_pkg::*;
#(
  parameter int INSTR_LEN  = 16,
  parameter int OPCODE_LEN = 5,
  parameter int CNT_LEN    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  bip_control_unit_if.master  bus,
  output logic                halted,
  output logic                illegal_op
`ifdef BIP_CYCLE_COUNT_EN
  ,
  output logic [CNT_LEN-1:0]  cycle_count
`endif
);

  // The decode table in bip_pkg is built for a fixed opcode width.
  if (OPCODE_LEN != OPCODE_W) begin : g_bad_opcode_len
    $error("OPCODE_LEN must equal bip_pkg::OPCODE_W");
  end
  if (CNT_LEN < 1) begin : g_bad_cnt_len
    $error("CNT_LEN must be at least 1");
  end

  state_t  state, state_next;
  ctrl_t   dec_ctrl, ctrl;
  logic    dec_illegal;
  opcode_t opcode;

  assign opcode = bus.instr_in[INSTR_LEN-1 -: OPCODE_LEN];

  bip_op_decoder u_dec (
    .opcode  (opcode),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // HLT is checked in RUN only, so a simultaneous start cannot keep the machine running.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (opcode == OP_HLT) state_next = HALT;
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  // Controls are live only while running; IDLE/HALT hold the PC and block all writes.
  assign ctrl = (state == RUN) ? dec_ctrl : '0;

  assign bus.pc_ena  = ctrl.pc_ena;
  assign bus.sel_a   = ctrl.sel_a;
  assign bus.sel_b   = ctrl.sel_b;
  assign bus.op_sub  = ctrl.op_sub;
  assign bus.wr_acc  = ctrl.wr_acc;
  assign bus.wr_ram  = ctrl.wr_ram;
  assign bus.rd_ram  = ctrl.rd_ram;
  assign bus.operand = bus.instr_in[INSTR_LEN-OPCODE_LEN-1:0];

  // state is a register, so this is a registered indication.
  assign halted = (state == HALT);

  always_ff @(posedge clk) begin
    if (reset)                             illegal_op <= 1'b0;
    else if (state == RUN && dec_illegal)  illegal_op <= 1'b1;
  end

`ifdef BIP_CYCLE_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      cycle_count <= '0;
    else if (state == RUN && cycle_count != {CNT_LEN{1'b1}})
      cycle_count <= cycle_count + 1'b1;
  end
`endif

endmodule
